// File: rtl/shared_bus_ctrl_pkg.sv
// Shared state encoding and default bus geometry for the shared bus controller.
package shared_bus_ctrl_pkg;

    localparam int DEF_WIDTH  = 32;
    localparam int DEF_ADDR_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_STB   = 3'd2,
        ST_TURN  = 3'd3,
        ST_RESP  = 3'd4
    } state_e;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Clear/enable saturating cycle counter. done_o marks the LIMIT-th enabled cycle,
// so the owner can leave its state on the edge that closes that cycle.
module bus_timeout_cnt #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic done_o
);

    localparam int            CW   = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);
    localparam logic [CW-1:0] MAX  = CW'(LIMIT);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at LIMIT.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CW{1'b0}};
        end else if (en_i && (cnt_q != MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = en_i && (cnt_q >= LAST);

endmodule

// File: rtl/shared_bus_ctrl.sv
// Single-master shared bus controller: turns a valid/ready request into a strobed
// read/write cycle with guaranteed turnaround and an ack timeout.
module shared_bus_ctrl
    import shared_bus_ctrl_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int TIMEOUT  = 15,
    parameter int TURN_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_wdata,
    output logic              rsp_valid,
    output logic [WIDTH-1:0]  rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [WIDTH-1:0]  bus_dout,
    output logic              bus_oe,
    input  logic [WIDTH-1:0]  bus_din,
    output logic              bus_wr_n,
    output logic              bus_rd_n,
    input  logic              bus_ack
);

    state_e            state_q;
    logic              wr_q;
    logic              err_q;
    logic [WIDTH-1:0]  rdata_q;
    logic [ADDR_W-1:0] bus_addr_q;
    logic [WIDTH-1:0]  bus_dout_q;
    logic              bus_oe_q;
    logic              bus_wr_n_q;
    logic              bus_rd_n_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [WIDTH-1:0]  rsp_rdata_q;
    logic              stb_done_s;
    logic              turn_done_s;

    bus_timeout_cnt #(.LIMIT(TIMEOUT)) u_stb_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q != ST_STB),
        .en_i   (state_q == ST_STB),
        .done_o (stb_done_s)
    );

    bus_timeout_cnt #(.LIMIT(TURN_CYC)) u_turn_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (state_q != ST_TURN),
        .en_i   (state_q == ST_TURN),
        .done_o (turn_done_s)
    );

    // Transfer sequencer; every bus and response output is registered here.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            wr_q        <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= {WIDTH{1'b0}};
            bus_addr_q  <= {ADDR_W{1'b0}};
            bus_dout_q  <= {WIDTH{1'b0}};
            bus_oe_q    <= 1'b0;
            bus_wr_n_q  <= 1'b1;
            bus_rd_n_q  <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= {WIDTH{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid) begin
                        state_q    <= ST_SETUP;
                        wr_q       <= req_write;
                        err_q      <= 1'b0;
                        rdata_q    <= {WIDTH{1'b0}};
                        bus_addr_q <= req_addr;
                        bus_oe_q   <= req_write;
                        if (req_write) begin
                            bus_dout_q <= req_wdata;
                        end else begin
                            bus_dout_q <= bus_dout_q;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_SETUP: begin
                    state_q    <= ST_STB;
                    bus_wr_n_q <= ~wr_q;
                    bus_rd_n_q <= wr_q;
                end
                ST_STB: begin
                    // An ack on the timeout edge still wins, so err is simply !ack.
                    if (bus_ack || stb_done_s) begin
                        state_q    <= ST_TURN;
                        bus_oe_q   <= 1'b0;
                        bus_wr_n_q <= 1'b1;
                        bus_rd_n_q <= 1'b1;
                        err_q      <= ~bus_ack;
                        if (bus_ack && !wr_q) begin
                            rdata_q <= bus_din;
                        end else begin
                            rdata_q <= rdata_q;
                        end
                    end else begin
                        state_q <= ST_STB;
                    end
                end
                ST_TURN: begin
                    if (turn_done_s) begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= err_q;
                        rsp_rdata_q <= (wr_q || err_q) ? {WIDTH{1'b0}} : rdata_q;
                    end else begin
                        state_q <= ST_TURN;
                    end
                end
                ST_RESP: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= {WIDTH{1'b0}};
                end
                default: begin
                    state_q     <= ST_IDLE;
                    bus_oe_q    <= 1'b0;
                    bus_wr_n_q  <= 1'b1;
                    bus_rd_n_q  <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    rsp_err_q   <= 1'b0;
                    rsp_rdata_q <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign bus_addr  = bus_addr_q;
    assign bus_dout  = bus_dout_q;
    assign bus_oe    = bus_oe_q;
    assign bus_wr_n  = bus_wr_n_q;
    assign bus_rd_n  = bus_rd_n_q;

endmodule
